systolic_mm_array: RTL and testbench

//   Parametrised NxN output-stationary systolic matrix multiplier: C = A*B (or C += A*B).

---
 rtl/systolic_mm_array.sv | 216 +++++++++++++++++++++
 tb/tb_systolic_mm_array.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_array.sv
// systolic_mm_array: NxN output-stationary systolic multiplier, C = A*B or C += A*B.
// Latency: start sampled in IDLE at edge t0; done pulses 3N cycles later with the full C.
// Backpressure: none; start is ignored while busy or during the done cycle (no queuing).
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         launch a multiply (only honoured in IDLE)
//   signed_mode   operand interpretation, captured with start (1 = two's complement)
//   acc_en        captured with start: 1 accumulates onto the held result, 0 overwrites
//   a_flat        A[i][k] at bits [(i*N+k)*DW +: DW]
//   b_flat        B[k][j] at bits [(k*N+j)*DW +: DW]
//   busy          multiply in progress
//   done          one-cycle pulse, c_flat carries the new result
//   c_flat        C[i][j] at bits [(i*N+j)*AW +: AW], held until the next done or reset
module systolic_mm_array #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 2*DW + $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_mode,
  input  logic                acc_en,
  input  logic [N*N*DW-1:0]   a_flat,
  input  logic [N*N*DW-1:0]   b_flat,
  output logic                busy,
  output logic                done,
  output logic [N*N*AW-1:0]   c_flat
);

  // Last RUN count; the final useful step is 3N-3, one spare cycle lets the
  // result be copied from fully settled accumulators.
  localparam int LAST = 3*N - 2;
  localparam int CW   = $clog2(3*N);
  localparam int KW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Operands latched at start so the inputs may change during the run.
  logic [DW-1:0]   a_m_q [N][N];
  logic [DW-1:0]   b_m_q [N][N];
  logic            sgn_q;

  // PE state: accumulator plus one pass register each for the rightward A
  // stream and downward B stream. The last column/row have no consumer, so
  // they carry no pass register.
  logic [AW-1:0]   acc_q [N][N];
  logic [DW-1:0]   pa_q  [N][N-1];
  logic [DW-1:0]   pb_q  [N-1][N];

  logic [N*N*AW-1:0] c_q;

  // Edge feeds and per-PE operands
  logic [DW-1:0]   a_feed [N];
  logic [DW-1:0]   b_feed [N];
  logic [DW-1:0]   pe_a   [N][N];
  logic [DW-1:0]   pe_b   [N][N];
  logic [AW-1:0]   prod   [N][N];

  logic            accept;
  logic            run_last;

  assign accept   = (state_q == S_IDLE) && start;
  assign run_last = (state_q == S_RUN) && (cnt_q == CW'(LAST));

  function automatic logic [AW-1:0] ext(input logic [DW-1:0] x, input logic sgn);
    ext = {{(AW-DW){sgn & x[DW-1]}}, x};
  endfunction

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAST)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Skewed edge feed: at step s row i presents A[i][s-i] and column j
  // presents B[s-j][j]; outside that window the feed is zero so the
  // accumulators only ever see valid products.
  // ---------------------------------------------------------------------
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < N; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
      k = int'(cnt_q) - i;
      if ((state_q == S_RUN) && (k >= 0) && (k < N)) begin
        a_feed[i] = a_m_q[i][k[KW-1:0]];
        b_feed[i] = b_m_q[k[KW-1:0]][i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // PE grid wiring
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign pe_a[gi][gj] = a_feed[gi];
      end else begin : g_a_pass
        assign pe_a[gi][gj] = pa_q[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign pe_b[gi][gj] = b_feed[gj];
      end else begin : g_b_pass
        assign pe_b[gi][gj] = pb_q[gi-1][gj];
      end
      // Low AW bits of the extended product are exact modulo 2^AW in both modes.
      assign prod[gi][gj] = ext(pe_a[gi][gj], sgn_q) * ext(pe_b[gi][gj], sgn_q);
    end
  end

  // ---------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_q <= 1'b0;
      c_q   <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_m_q[i][j] <= '0;
          b_m_q[i][j] <= '0;
          acc_q[i][j] <= '0;
        end
        for (int j = 0; j < N-1; j++) begin
          pa_q[i][j] <= '0;
          pb_q[j][i] <= '0;
        end
      end
    end else if (accept) begin
      sgn_q <= signed_mode;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_m_q[i][j] <= a_flat[(i*N+j)*DW +: DW];
          b_m_q[i][j] <= b_flat[(i*N+j)*DW +: DW];
          // Accumulate mode seeds each PE with the currently visible result.
          acc_q[i][j] <= acc_en ? c_q[(i*N+j)*AW +: AW] : '0;
        end
        for (int j = 0; j < N-1; j++) begin
          pa_q[i][j] <= '0;
          pb_q[j][i] <= '0;
        end
      end
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= acc_q[i][j] + prod[i][j];
        end
        for (int j = 0; j < N-1; j++) begin
          pa_q[i][j] <= pe_a[i][j];
          pb_q[j][i] <= pe_b[j][i];
        end
      end
      // Publish all elements at once; c_flat never exposes partial sums.
      if (run_last) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            c_q[(i*N+j)*AW +: AW] <= acc_q[i][j];
          end
        end
      end
    end
  end

  assign c_flat = c_q;

endmodule

// File: tb/tb_systolic_mm_array.sv
// tb_systolic_mm_array: directed table-driven bench for the 4x4 systolic multiplier.
// Latency: expects done 12 sampled cycles after the start edge, busy for 11.
// Backpressure: exercises ignored mid-run start, mid-run reset and held start.
module tb_systolic_mm_array;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2*DW + $clog2(N);

  typedef logic [N*N*DW-1:0] opnd_t;
  typedef logic [N*N*AW-1:0] res_t;

  typedef struct {
    string name;
    logic  sm;
    logic  ae;
    opnd_t a;
    opnd_t b;
    res_t  c;
  } vec_t;

  logic  clk;
  logic  rst;
  logic  start;
  logic  signed_mode;
  logic  acc_en;
  opnd_t a_flat;
  opnd_t b_flat;
  logic  busy;
  logic  done;
  res_t  c_flat;

  int checks = 0;
  int errors = 0;

  systolic_mm_array #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .acc_en      (acc_en),
    .a_flat      (a_flat),
    .b_flat      (b_flat),
    .busy        (busy),
    .done        (done),
    .c_flat      (c_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  // ---------------- operand / result builders (hand formulas) ----------
  function automatic opnd_t op_const(input logic [DW-1:0] v);
    opnd_t r;
    for (int e = 0; e < N*N; e++) r[e*DW +: DW] = v;
    return r;
  endfunction

  function automatic opnd_t op_ident();
    opnd_t r;
    r = '0;
    for (int i = 0; i < N; i++) r[(i*N+i)*DW +: DW] = DW'(1);
    return r;
  endfunction

  // kind 0: element (r,c) = r*N+c ; kind 1: r+1 ; kind 2: c+1
  function automatic opnd_t op_pat(input int kind);
    opnd_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*DW +: DW] = (kind == 0) ? DW'(i*N+j) : (kind == 1) ? DW'(i+1) : DW'(j+1);
    return r;
  endfunction

  function automatic res_t res_const(input logic [AW-1:0] v);
    res_t r;
    for (int e = 0; e < N*N; e++) r[e*AW +: AW] = v;
    return r;
  endfunction

  function automatic res_t res_ident(input int v);
    res_t r;
    r = '0;
    for (int i = 0; i < N; i++) r[(i*N+i)*AW +: AW] = AW'(v);
    return r;
  endfunction

  // kind 0: C(i,j) = i*N+j ; kind 1: 4*(i+1)*(j+1)
  function automatic res_t res_pat(input int kind);
    res_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*AW +: AW] = (kind == 0) ? AW'(i*N+j) : AW'(4*(i+1)*(j+1));
    return r;
  endfunction

  task automatic chk(input string nm, input res_t act, input res_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Launch one op, scramble the inputs right after the start edge, and
  // check latency, busy length, result stability, result and pulse width.
  task automatic run_op(input string nm, input logic sm, input logic ae,
                        input opnd_t a, input opnd_t b, input res_t exp_c);
    int   lat;
    int   bc;
    logic stable;
    res_t c_before;
    @(negedge clk);
    signed_mode = sm;
    acc_en      = ae;
    a_flat      = a;
    b_flat      = b;
    start       = 1'b1;
    c_before    = c_flat;
    @(posedge clk);
    #1;
    start       = 1'b0;
    a_flat      = ~a;
    b_flat      = {b[N*N*DW-9:0], 8'h5A};
    signed_mode = ~sm;
    acc_en      = ~ae;
    lat = -1;
    bc = 0;
    stable = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = n;
        break;
      end
      if (c_flat !== c_before) stable = 1'b0;
    end
    chk({nm, " latency"}, res_t'(lat), res_t'(12));
    chk({nm, " busy_cycles"}, res_t'(bc), res_t'(11));
    chk({nm, " no_partial"}, res_t'(stable), res_t'(1));
    chk({nm, " result"}, c_flat, exp_c);
    @(negedge clk);
    chk({nm, " pulse_end"}, res_t'({done, busy}), res_t'(0));
  endtask

  vec_t vecs[10];

  initial begin
    int   done_cnt;
    int   done_at;
    int   d1;
    int   d2;
    res_t c_at;

    vecs[0] = '{"ident_x_seq", 1'b0, 1'b0, op_ident(),        op_pat(0),       res_pat(0)};
    vecs[1] = '{"u255",        1'b0, 1'b0, op_const(8'hFF),   op_const(8'hFF), res_const(18'd260100)};
    vecs[2] = '{"s_m128",      1'b1, 1'b0, op_const(8'h80),   op_const(8'h80), res_const(18'd65536)};
    vecs[3] = '{"s_m1x1",      1'b1, 1'b0, op_const(8'hFF),   op_const(8'h01), res_const(18'h3FFFC)};
    vecs[4] = '{"u_ffx1",      1'b0, 1'b0, op_const(8'hFF),   op_const(8'h01), res_const(18'd1020)};
    vecs[5] = '{"outer",       1'b0, 1'b0, op_pat(1),         op_pat(2),       res_pat(1)};
    vecs[6] = '{"s_m1xrow",    1'b1, 1'b0, op_const(8'hFF),   op_pat(1),       res_const(18'h3FFF6)};
    vecs[7] = '{"acc_op1",     1'b0, 1'b0, op_ident(),        op_ident(),      res_ident(1)};
    vecs[8] = '{"acc_op2",     1'b0, 1'b1, op_ident(),        op_ident(),      res_ident(2)};
    vecs[9] = '{"acc_op3",     1'b0, 1'b0, op_ident(),        op_ident(),      res_ident(1)};

    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    acc_en = 1'b0;
    a_flat = '0;
    b_flat = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", res_t'(busy), res_t'(0));
    chk("reset done", res_t'(done), res_t'(0));
    chk("reset c_flat", c_flat, '0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++)
      run_op(vecs[v].name, vecs[v].sm, vecs[v].ae, vecs[v].a, vecs[v].b, vecs[v].c);

    // Start pulse three cycles into a run must be dropped.
    @(negedge clk);
    signed_mode = 1'b0;
    acc_en = 1'b0;
    a_flat = op_ident();
    b_flat = op_pat(0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    done_at = -1;
    c_at = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          c_at = c_flat;
        end
      end
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
    end
    chk("midstart done_count", res_t'(done_cnt), res_t'(1));
    chk("midstart done_at", res_t'(done_at), res_t'(12));
    chk("midstart result", c_at, res_pat(0));

    // Reset five cycles into a run aborts it.
    @(negedge clk);
    a_flat = op_const(8'hFF);
    b_flat = op_const(8'hFF);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", res_t'(busy), res_t'(0));
    chk("midrst c_flat", c_flat, '0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midrst no_done", res_t'(done_cnt), res_t'(0));
    run_op("post_rst_acc", 1'b0, 1'b1, op_ident(), op_ident(), res_ident(1));

    // Start held high: one op accepted every 3N+1 cycles.
    @(negedge clk);
    signed_mode = 1'b0;
    acc_en = 1'b0;
    a_flat = op_ident();
    b_flat = op_pat(0);
    start = 1'b1;
    d1 = -1;
    d2 = -1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) begin
          d2 = n;
          c_at = c_flat;
        end
      end
    end
    start = 1'b0;
    chk("b2b first_done", res_t'(d1), res_t'(12));
    chk("b2b period", res_t'(d2 - d1), res_t'(13));
    chk("b2b result", c_at, res_pat(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
